switch_scan_ctrl: RTL and testbench
===================================

# switch_scan_ctrl

Scan controller that shares one debounce engine across `N_SW` raw switch inputs in round-robin order. It produces a debounced level per switch, plus a queued stream of press/release events on a valid/ready handshake. It sits between the board switch pins and the user-interface logic. It replaces per-switch free-running debouncers with one sequenced, sample-rate-controlled engine.

## Interface
Parameters:
- `N_SW`, 4: number of switch channels; legal range 2..16.
- `HIST`, 10: samples of history per channel; a level change requires `HIST` consecutive equal samples.
- `TICK_DIV`, 50000: clocks per sample tick; must satisfy `TICK_DIV >= N_SW + 2`.
- `FIFO_DEPTH`, 4: event queue entries; must be a power of 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `switch_in`  in  N_SW  raw asynchronous switch pins.
- `sw_level`  out  N_SW  debounced level per channel.
- `evt_valid`  out  1  head event available.
- `evt_ready`  in  1  consumer accepts head event.
- `evt_id`  out  $clog2(N_SW)  channel of the head event.
- `evt_press`  out  1  1 = rising (press), 0 = falling (release).
- `evt_overflow`  out  1  sticky flag: an event was dropped.
- `clear_ovf`  in  1  one-cycle pulse that clears `evt_overflow`.

## Operation
- **Input sync:** `switch_in` passes through a 2-flop synchronizer per bit. The engine only samples the synchronized value.
- **Prescaler:**
  - Counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is asserted for one cycle when the count equals `TICK_DIV`-1.
- **FSM states:**
  - IDLE: waits for `tick`, then moves to SCAN with `ch`=0.
  - SCAN: processes channel `ch` once per cycle.
  - After `ch`=`N_SW`-1 the FSM returns to IDLE.
  - A `tick` while in SCAN cannot occur, given the `TICK_DIV` constraint.
- **Per-channel step (SCAN):**
  - `hist[ch] <= {hist[ch][HIST-2:0], sync[ch]}`.
  - The decision uses the new history value.
  - If the new history is all ones and `sw_level[ch]`=0: set the level to 1 and push {ch, press=1}.
  - If the new history is all zeros and `sw_level[ch]`=1: set the level to 0 and push {ch, press=0}.
  - Otherwise there is no change.
- **Event FIFO:**
  - Depth `FIFO_DEPTH`, first-word-fall-through.
  - `evt_id`/`evt_press` are valid whenever `evt_valid`=1.
  - A pop occurs when `evt_valid` and `evt_ready` are both 1.
  - Push when full without a pop that cycle: the event is dropped and `evt_overflow` is set to 1.
  - Push when full with a simultaneous pop: the push is accepted.
  - Push and pop while not full: both occur and occupancy is unchanged.
- **Overflow flag:**
  - `clear_ovf` clears `evt_overflow`.
  - If a drop and `clear_ovf` occur in the same cycle, the flag stays set (set wins).
- **Reset:**
  - Cleared to 0: prescaler, all `hist`, `sw_level`, synchronizers, FIFO pointers and count, `evt_overflow`.
  - FSM returns to IDLE.
  - `evt_valid`=0, `evt_id`=0, `evt_press`=0.
  - Reset in mid-SCAN abandons the scan. No partial event survives.

## Timing
- Synchronizer latency is 2 cycles from pin to `sync`.
- If `tick` is high in cycle T, channel k is processed in cycle T+1+k.
- `sw_level[k]` and the FIFO write take effect at the end of that cycle.
- With the FIFO empty, `evt_valid` rises in cycle T+2+k.
- A pop in cycle P exposes the next entry, or drops `evt_valid`, in cycle P+1.
- Worst-case debounce latency is `HIST` ticks plus scan position plus 3 cycles.
- No combinational path from `evt_ready` to `evt_valid`.

## Test plan
Use `N_SW`=4, `HIST`=4, `TICK_DIV`=8, `FIFO_DEPTH`=4.
1. **Reset:** assert `reset` 3 cycles with random `switch_in`. Required: all outputs 0. The first `tick` comes 8 cycles after reset deasserts.
2. **Clean press:** `switch_in`=4'b0100, held steady from reset release, `evt_ready`=1.
   - After the 4th tick, `sw_level`=4'b0100.
   - Exactly one event {id=2, press=1}, with `evt_valid` high exactly 1 cycle.
   - Drop the input to 0: {id=2, press=0} after 4 further ticks.
3. **Bounce rejection:** toggle `switch_in[1]` as 1,1,1,0,1,1,1,0 per tick. Required: `sw_level[1]` stays 0 and no events.
4. **Overflow:** `evt_ready`=0, then create 5 press events (ch0–3 press, then ch0 release).
   - Required: `evt_valid`=1, 4 entries in order 0,1,2,3, `evt_overflow`=1.
   - Pulse `clear_ovf`: the flag clears.
   - Pulse `clear_ovf` in the same cycle as another drop: the flag stays 1.
5. **Full push+pop:** with the FIFO full, pulse `evt_ready` exactly in the cycle a new event is pushed. Required: no overflow, and the new event is the 4th entry.
6. **Mid-scan reset:** assert `reset` in cycle T+2 of a scan that would generate an event on ch3. Required: no event, all `sw_level`=0, and the FSM restarts cleanly.

Source files
------------

// File: rtl/switch_scan_ctrl_if.sv
// Event stream between the scan controller and its consumer.
// The controller is the master: it drives valid/id/press and samples ready.
interface switch_scan_ctrl_if #(
    parameter int N_SW = 4
);
    logic                    evt_valid;
    logic                    evt_ready;
    logic [$clog2(N_SW)-1:0] evt_id;
    logic                    evt_press;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_press,
        output evt_ready
    );
endinterface

// File: rtl/switch_scan_ctrl.sv
// Round-robin switch debouncer: one shared history engine visits every channel
// once per sample tick and queues press/release events in a small FWFT FIFO.
module switch_scan_ctrl #(
    parameter int N_SW       = 4,
    parameter int HIST       = 10,
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SW-1:0]    switch_in,
    output logic [N_SW-1:0]    sw_level,
    switch_scan_ctrl_if.master evt,
    output logic               evt_overflow,
    input  logic               clear_ovf
);
    localparam int ID_W  = $clog2(N_SW);
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ch;
    logic [ID_W-1:0]   w_ch_nxt;
    logic              w_scan;
    logic [PS_W-1:0]   r_presc;
    logic              w_tick;
    logic [N_SW-1:0]   r_sync1;
    logic [N_SW-1:0]   r_sync2;
    logic [HIST-1:0]   r_hist [N_SW];
    logic [HIST-1:0]   w_hist_cur;
    logic [HIST-1:0]   w_hist_new;
    logic              w_push;
    logic              w_push_press;
    logic [ID_W-1:0]   r_mem_id    [FIFO_DEPTH];
    logic              r_mem_press [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_valid;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_drop;

    assign w_tick = (r_presc == PS_W'(TICK_DIV - 1));

    // Sample-rate prescaler and two-flop pin synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            r_sync1 <= switch_in;
            r_sync2 <= r_sync1;
        end
    end

    // Scan sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    // Next-state logic: one channel per cycle after each tick.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_scan      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_nxt = SCAN;
                    w_ch_nxt    = '0;
                end else begin
                    w_ch_nxt    = '0;
                end
            end
            SCAN: begin
                w_scan = 1'b1;
                if (r_ch == ID_W'(N_SW - 1)) begin
                    w_state_nxt = IDLE;
                    w_ch_nxt    = '0;
                end else begin
                    w_ch_nxt    = r_ch + ID_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ch_nxt    = '0;
            end
        endcase
    end

    // Decision uses the history including this cycle's sample.
    always_comb begin
        w_hist_cur   = r_hist[r_ch];
        w_hist_new   = (w_hist_cur << 1) | HIST'(r_sync2[r_ch]);
        w_push_press = &w_hist_new;
        w_push       = 1'b0;
        if (w_scan) begin
            w_push = ((&w_hist_new) && !sw_level[r_ch]) ||
                     ((~|w_hist_new) && sw_level[r_ch]);
        end else begin
            w_push = 1'b0;
        end
    end

    // Per-channel history and debounced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SW; i++) begin
                r_hist[i] <= '0;
            end
            sw_level <= '0;
        end else if (w_scan) begin
            r_hist[r_ch] <= w_hist_new;
            if (w_push) begin
                sw_level[r_ch] <= w_push_press;
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && evt.evt_ready;
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_id[i]    <= '0;
                r_mem_press[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem_id[r_wr_ptr]    <= r_ch;
                r_mem_press[r_wr_ptr] <= w_push_press;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_overflow <= 1'b0;
        end else if (w_drop) begin
            evt_overflow <= 1'b1;
        end else if (clear_ovf) begin
            evt_overflow <= 1'b0;
        end
    end

    // Head of queue, held at zero while the queue is empty.
    always_comb begin
        evt.evt_valid = w_valid;
        if (w_valid) begin
            evt.evt_id    = r_mem_id[r_rd_ptr];
            evt.evt_press = r_mem_press[r_rd_ptr];
        end else begin
            evt.evt_id    = '0;
            evt.evt_press = 1'b0;
        end
    end
endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Randomized bench for switch_scan_ctrl, compared each cycle against a
// run-length / event-queue reference model.
module tb_switch_scan_ctrl;
    localparam int N_SW       = 4;
    localparam int HIST       = 4;
    localparam int TICK_DIV   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LOG_LEN    = 4096;

    typedef struct {
        int id;
        bit press;
    } evt_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_SW-1:0] switch_in;
    logic [N_SW-1:0] sw_level;
    logic            evt_overflow;
    logic            clear_ovf;

    switch_scan_ctrl_if #(.N_SW(N_SW)) evt_if ();

    switch_scan_ctrl #(
        .N_SW(N_SW), .HIST(HIST), .TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .switch_in    (switch_in),
        .sw_level     (sw_level),
        .evt          (evt_if),
        .evt_overflow (evt_overflow),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    int              abs_cyc = 0;
    int              mcyc = 0;
    logic [N_SW-1:0] pin_log [LOG_LEN];
    bit   [N_SW-1:0] m_level;
    bit   [N_SW-1:0] m_run_val;
    int              m_run_len [N_SW];
    evt_t            m_q [$];
    bit              m_ovf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, abs_cyc);
        end
    endtask

    task automatic model_reset();
        m_level   = '0;
        m_run_val = '0;
        for (int i = 0; i < N_SW; i++) m_run_len[i] = HIST;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit rst, input logic [N_SW-1:0] pins, input bit rdy, input bit clr);
        int   k;
        bit   s;
        bit   push;
        bit   press;
        bit   drop;
        bit   pop;
        evt_t e;
        pin_log[abs_cyc % LOG_LEN] = pins;
        push  = 1'b0;
        press = 1'b0;
        drop  = 1'b0;
        k     = 0;
        if (rst) begin
            model_reset();
            mcyc = 0;
        end else begin
            pop = (m_q.size() != 0) && rdy;
            if (mcyc >= TICK_DIV && (mcyc % TICK_DIV) < N_SW) begin
                k = mcyc % TICK_DIV;
                s = pin_log[(abs_cyc - 2) % LOG_LEN][k];
                if (s == m_run_val[k]) begin
                    m_run_len[k]++;
                end else begin
                    m_run_val[k] = s;
                    m_run_len[k] = 1;
                end
                if (m_run_len[k] >= HIST && m_run_val[k] != m_level[k]) begin
                    m_level[k] = s;
                    push       = 1'b1;
                    press      = s;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FIFO_DEPTH) begin
                    e.id    = k;
                    e.press = press;
                    m_q.push_back(e);
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            mcyc++;
        end
        abs_cyc++;
    endtask

    task automatic compare_outputs();
        bit         ev;
        logic [1:0] eid;
        bit         ep;
        ev  = (m_q.size() != 0);
        eid = ev ? 2'(m_q[0].id) : 2'd0;
        ep  = ev ? m_q[0].press : 1'b0;
        check_val("sw_level",     32'(sw_level),         32'(m_level));
        check_val("evt_valid",    32'(evt_if.evt_valid), 32'(ev));
        check_val("evt_id",       32'(evt_if.evt_id),    32'(eid));
        check_val("evt_press",    32'(evt_if.evt_press), 32'(ep));
        check_val("evt_overflow", 32'(evt_overflow),     32'(m_ovf));
    endtask

    task automatic cycle(input bit rst, input logic [N_SW-1:0] pins, input bit rdy, input bit clr);
        @(negedge clk);
        compare_outputs();
        reset            = rst;
        switch_in        = pins;
        evt_if.evt_ready = rdy;
        clear_ovf        = clr;
        model_step(rst, pins, rdy, clr);
    endtask

    task automatic run(input int n, input logic [N_SW-1:0] pins, input bit rdy, input bit clr);
        for (int i = 0; i < n; i++) cycle(1'b0, pins, rdy, clr);
    endtask

    initial begin
        logic [N_SW-1:0] cur;
        bit              bouncy;
        bit              found;

        model_reset();
        reset            = 1'b1;
        switch_in        = N_SW'($urandom);
        evt_if.evt_ready = 1'b0;
        clear_ovf        = 1'b0;
        model_step(1'b1, switch_in, 1'b0, 1'b0);
        cycle(1'b1, N_SW'($urandom), 1'b0, 1'b0);
        cycle(1'b1, N_SW'($urandom), 1'b0, 1'b0);

        // clean press on channel 2, then release
        run(60, 4'b0100, 1'b1, 1'b0);
        run(50, 4'b0000, 1'b1, 1'b0);

        // channel 1 bouncing 1,1,1,0 per tick
        for (int i = 0; i < 96; i++) begin
            cycle(1'b0, (((mcyc / TICK_DIV) % 4) != 3) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
        end
        run(50, 4'b0000, 1'b1, 1'b0);

        // overflow with the consumer stalled, clear, then drops under clear
        run(60, 4'b1111, 1'b0, 1'b0);
        run(60, 4'b0000, 1'b0, 1'b0);
        run(1,  4'b0000, 1'b0, 1'b1);
        run(5,  4'b0000, 1'b0, 1'b0);
        run(60, 4'b1111, 1'b0, 1'b1);
        run(30, 4'b1111, 1'b1, 1'b0);

        // reset two cycles into the scan that would raise channel 3
        run(50, 4'b0000, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mcyc >= TICK_DIV && (mcyc % TICK_DIV) == 1 && m_run_val[3] == 1'b1 &&
                m_run_len[3] == HIST - 1 && m_level[3] == 1'b0) begin
                cycle(1'b1, 4'b1000, 1'b1, 1'b0);
                found = 1'b1;
            end else begin
                cycle(1'b0, 4'b1000, 1'b1, 1'b0);
            end
        end
        check_val("midscan_found", 32'(found), 32'd1);
        run(3, 4'b1000, 1'b1, 1'b0);
        run(60, 4'b1000, 1'b1, 1'b0);

        // random traffic: steady and bouncy pins, random ready/clear, rare reset
        cur    = '0;
        bouncy = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ((i % 24) == 0) begin
                cur    = N_SW'($urandom);
                bouncy = ($urandom_range(0, 3) == 0);
            end
            cycle(($urandom_range(0, 499) == 0),
                  bouncy ? N_SW'($urandom) : cur,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 31) == 0);
        end
        run(2, cur, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
